axis_16b_vid_out: RTL and testbench



---
 rtl/axis_vid_out_pkg.sv | 15 +
 rtl/axis_vid_out_fifo.sv | 47 ++++
 rtl/axis_16b_vid_out.sv | 199 +++++++++++++++++++
 tb/tb_axis_16b_vid_out.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_vid_out_pkg.sv
// Shared types for the AXI4-Stream to parallel video output block:
// lock state machine encoding and FIFO word field layout.
package axis_vid_out_pkg;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    WAIT_VTG = 2'd1,
    LOCKED   = 2'd2
  } vid_out_state_t;

  // FIFO word is {tlast, tuser, tdata}; offsets are counted above the pixel field
  localparam int TUSER_BIT = 0;
  localparam int TLAST_BIT = 1;

endpackage

// File: rtl/axis_vid_out_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry a wrap bit so
// full and empty are distinguished without a separate counter.
module axis_vid_out_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axis_16b_vid_out.sv
// AXI4-Stream video to parallel video locked to an external VTG.
// Optional end-of-line tlast checking is built when AXIS_VID_OUT_EOL_CHECK_EN is defined.
module axis_16b_vid_out
  import axis_vid_out_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    vtg_vblank,
  input  logic                    vtg_vsync,
  input  logic                    vtg_hblank,
  input  logic                    vtg_hsync,
  input  logic                    vtg_active_video,
  input  logic                    vtg_field_id,
  output logic                    vid_vblank,
  output logic                    vid_vsync,
  output logic                    vid_hblank,
  output logic                    vid_hsync,
  output logic                    vid_active_video,
  output logic                    vid_field_id,
  output logic [DATA_WIDTH-1:0]   vid_data,
  output logic                    locked,
  output logic                    underflow,
  output logic                    sof_err
);

  localparam int WORD_W = DATA_WIDTH + 2;

  vid_out_state_t    state;
  vid_out_state_t    next_state;
  logic              vb_seen;
  logic              vtg_sof;
  logic [WORD_W-1:0] fifo_din;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_tuser;
  logic              err_uf;
  logic              err_sof;
  logic              err_eol;
  logic              pixel_ok;

  assign fifo_din   = {s_axis_tlast, s_axis_tuser, s_axis_tdata};
  assign head_tuser = fifo_dout[DATA_WIDTH + TUSER_BIT];
  assign vtg_sof    = vtg_active_video && vb_seen;
  assign locked     = (state == LOCKED);

  axis_vid_out_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // First active pixel after any vblank marks the VTG frame start
  always_ff @(posedge aclk) begin
    if (reset)                 vb_seen <= 1'b0;
    else if (vtg_active_video) vb_seen <= 1'b0;
    else if (vtg_vblank)       vb_seen <= 1'b1;
  end

`ifdef AXIS_VID_OUT_EOL_CHECK_EN
  logic eol_pending;
  logic eol_tlast;
  logic unused_in;

  assign unused_in = ^s_axis_tkeep;

  always_ff @(posedge aclk) begin
    if (reset || fifo_flush) begin
      eol_pending <= 1'b0;
      eol_tlast   <= 1'b0;
    end else begin
      eol_pending <= pixel_ok;
      eol_tlast   <= fifo_dout[DATA_WIDTH + TLAST_BIT];
    end
  end

  // tlast must mark the pixel whose successor is blanking
  assign err_eol = (state == LOCKED) && eol_pending && (eol_tlast == vtg_active_video);
`else
  logic unused_in;

  assign unused_in = ^{s_axis_tkeep, fifo_dout[DATA_WIDTH + TLAST_BIT]};
  assign err_eol   = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (reset) state <= SYNC;
    else       state <= next_state;
  end

  // Underflow outranks a framing error when both hit the same pixel
  always_comb begin
    next_state = state;
    err_uf     = 1'b0;
    err_sof    = 1'b0;
    case (state)
      SYNC: begin
        if (s_axis_tvalid && s_axis_tuser) next_state = WAIT_VTG;
      end
      WAIT_VTG: begin
        if (vtg_sof && !fifo_empty) next_state = LOCKED;
      end
      LOCKED: begin
        if (vtg_active_video && fifo_empty)
          err_uf = 1'b1;
        else if ((vtg_active_video && (head_tuser != vtg_sof)) || err_eol)
          err_sof = 1'b1;
        if (err_uf || err_sof) next_state = SYNC;
      end
      default: next_state = SYNC;
    endcase
  end

  // The SOF pop in WAIT_VTG carries the first displayed pixel of the frame
  always_comb begin
    s_axis_tready = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    pixel_ok      = 1'b0;
    case (state)
      SYNC: begin
        s_axis_tready = 1'b1;
        fifo_push     = s_axis_tvalid && s_axis_tuser;
      end
      WAIT_VTG: begin
        s_axis_tready = !fifo_full;
        fifo_push     = s_axis_tvalid && !fifo_full;
        if (vtg_sof && !fifo_empty) begin
          fifo_pop = 1'b1;
          pixel_ok = 1'b1;
        end
      end
      LOCKED: begin
        if (err_uf || err_sof) begin
          fifo_flush = 1'b1;
        end else begin
          s_axis_tready = !fifo_full;
          fifo_push     = s_axis_tvalid && !fifo_full;
          if (vtg_active_video) begin
            fifo_pop = 1'b1;
            pixel_ok = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (reset) begin
      s_axis_tready = 1'b0;
      fifo_push     = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      vid_vblank       <= 1'b0;
      vid_vsync        <= 1'b0;
      vid_hblank       <= 1'b0;
      vid_hsync        <= 1'b0;
      vid_active_video <= 1'b0;
      vid_field_id     <= 1'b0;
      vid_data         <= '0;
      underflow        <= 1'b0;
      sof_err          <= 1'b0;
    end else begin
      vid_vblank       <= vtg_vblank;
      vid_vsync        <= vtg_vsync;
      vid_hblank       <= vtg_hblank;
      vid_hsync        <= vtg_hsync;
      vid_active_video <= vtg_active_video;
      vid_field_id     <= vtg_field_id;
      vid_data         <= pixel_ok ? fifo_dout[DATA_WIDTH-1:0] : '0;
      underflow        <= err_uf;
      sof_err          <= err_sof;
    end
  end

endmodule

// File: tb/tb_axis_16b_vid_out.sv
// Scoreboard bench for axis_16b_vid_out: an 8x4 VTG with 4-pixel blanking,
// a beat-queue stream driver and a monitor popping expected pixels.
module tb_axis_16b_vid_out;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int H_ACT = 8;
  localparam int H_TOT = 12;
  localparam int V_ACT = 4;
  localparam int V_TOT = 6;

`ifdef AXIS_VID_OUT_EOL_CHECK_EN
  localparam int EOL_EXP_PIX = 6;
  localparam int EOL_EXP_ERR = 1;
`else
  localparam int EOL_EXP_PIX = 32;
  localparam int EOL_EXP_ERR = 0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
    int            gap;
  } beat_t;

  logic          aclk;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [1:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          vtg_vblank, vtg_vsync, vtg_hblank, vtg_hsync, vtg_active_video, vtg_field_id;
  logic          vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id;
  logic [DW-1:0] vid_data;
  logic          locked;
  logic          underflow;
  logic          sof_err;

  beat_t         beat_q[$];
  logic [DW-1:0] exp_q[$];
  int            total;
  int            bad;
  int            uf_cnt;
  int            se_cnt;
  int            accepted_cnt;
  bit            saw_full;
  bit            bp_check;
  logic [5:0]    prev_vtg;
  logic          rst_at_edge;
  logic [DW-1:0] mon_exp;

  axis_16b_vid_out #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk             (aclk),
    .reset            (reset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .vtg_vblank       (vtg_vblank),
    .vtg_vsync        (vtg_vsync),
    .vtg_hblank       (vtg_hblank),
    .vtg_hsync        (vtg_hsync),
    .vtg_active_video (vtg_active_video),
    .vtg_field_id     (vtg_field_id),
    .vid_vblank       (vid_vblank),
    .vid_vsync        (vid_vsync),
    .vid_hblank       (vid_hblank),
    .vid_hsync        (vid_hsync),
    .vid_active_video (vid_active_video),
    .vid_field_id     (vid_field_id),
    .vid_data         (vid_data),
    .locked           (locked),
    .underflow        (underflow),
    .sof_err          (sof_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Free-running VTG, starting inside vertical blanking
  initial begin
    int hcnt;
    int vcnt;
    hcnt = 0;
    vcnt = V_ACT;
    {vtg_vblank, vtg_vsync, vtg_hblank, vtg_hsync, vtg_active_video, vtg_field_id} = '0;
    forever begin
      @(negedge aclk);
      vtg_active_video = (hcnt < H_ACT) && (vcnt < V_ACT);
      vtg_hblank       = (hcnt >= H_ACT);
      vtg_hsync        = (hcnt == 9);
      vtg_vblank       = (vcnt >= V_ACT);
      vtg_vsync        = (vcnt == V_ACT);
      hcnt = hcnt + 1;
      if (hcnt == H_TOT) begin
        hcnt = 0;
        vcnt = vcnt + 1;
        if (vcnt == V_TOT) begin
          vcnt = 0;
          vtg_field_id = ~vtg_field_id;
        end
      end
    end
  end

  // Stream driver: presents the head beat, honours its idle gap, pops on handshake
  initial begin
    bit acc_pending;
    int gap_cnt;
    acc_pending   = 1'b0;
    gap_cnt       = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '1;
    forever begin
      @(negedge aclk);
      if (acc_pending && beat_q.size() > 0) begin
        void'(beat_q.pop_front());
        accepted_cnt = accepted_cnt + 1;
        gap_cnt = 0;
      end
      if (beat_q.size() > 0 && gap_cnt >= beat_q[0].gap) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_q[0].data;
        s_axis_tuser  = beat_q[0].user;
        s_axis_tlast  = beat_q[0].last;
      end else begin
        s_axis_tvalid = 1'b0;
        if (beat_q.size() > 0) gap_cnt = gap_cnt + 1;
      end
      #1 acc_pending = s_axis_tvalid && s_axis_tready;
    end
  end

  always @(posedge aclk) begin
    prev_vtg    <= {vtg_vblank, vtg_vsync, vtg_hblank, vtg_hsync, vtg_active_video, vtg_field_id};
    rst_at_edge <= reset;
  end

  // Monitor: timing passthrough, scoreboard pops, blanking zeros, error side effects
  initial begin
    forever begin
      @(negedge aclk);
      #2;
      if (rst_at_edge === 1'b0) begin
        total = total + 1;
        if ({vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id} !== prev_vtg) begin
          bad = bad + 1;
          $display("[TB] FAIL vid_timing: got %b want %b", {vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id}, prev_vtg);
        end
        if (underflow === 1'b1) uf_cnt = uf_cnt + 1;
        if (sof_err === 1'b1) se_cnt = se_cnt + 1;
        if (vid_active_video === 1'b1 && locked === 1'b1) begin
          total = total + 1;
          if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("[TB] FAIL extra_pixel: got %h want none", vid_data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (vid_data !== mon_exp) begin
              bad = bad + 1;
              $display("[TB] FAIL pixel: got %h want %h", vid_data, mon_exp);
            end
          end
        end else begin
          total = total + 1;
          if (vid_data !== '0) begin
            bad = bad + 1;
            $display("[TB] FAIL idle_data: got %h want 0", vid_data);
          end
        end
        if (underflow === 1'b1 || sof_err === 1'b1) begin
          total = total + 1;
          if (locked !== 1'b0 || dut.u_fifo.empty !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL error_exit: got locked=%b empty=%b want locked=0 empty=1", locked, dut.u_fifo.empty);
          end
        end
        if (bp_check && locked === 1'b1) begin
          total = total + 1;
          if (s_axis_tready !== !dut.u_fifo.full) begin
            bad = bad + 1;
            $display("[TB] FAIL tready_full: got tready=%b full=%b want tready=!full", s_axis_tready, dut.u_fifo.full);
          end
          if (dut.u_fifo.full === 1'b1) saw_full = 1'b1;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout want test end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic start_test();
    @(negedge aclk);
    reset = 1'b1;
    repeat (3) @(negedge aclk);
    beat_q.delete();
    exp_q.delete();
    uf_cnt       = 0;
    se_cnt       = 0;
    accepted_cnt = 0;
    saw_full     = 1'b0;
    bp_check     = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
  endtask

  task automatic add_frame(input logic [DW-1:0] base, input int user2, input int n_exp,
                           input int gap_idx, input int gap_len, input int eol_pix);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.data = base + DW'(i);
      b.user = (i == 0) || (i == user2);
      b.last = (i % 8 == 7) || (i == eol_pix);
      b.gap  = (i == gap_idx) ? gap_len : 0;
      beat_q.push_back(b);
      if (i < n_exp) exp_q.push_back(b.data);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_reset();
    bit got_lock;
    @(negedge aclk);
    reset = 1'b1;
    @(negedge aclk);
    #2;
    total = total + 1;
    if ({s_axis_tready, locked, vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id, underflow, sof_err} !== '0) begin
      bad = bad + 1;
      $display("[TB] FAIL reset_ctrl: got %b want 0", {s_axis_tready, locked, vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id, underflow, sof_err});
    end
    total = total + 1;
    if (vid_data !== '0) begin
      bad = bad + 1;
      $display("[TB] FAIL reset_data: got %h want 0", vid_data);
    end
    start_test();
    add_frame(16'h0001, -1, 32, -1, 0, -1);
    got_lock = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge aclk);
      if (locked === 1'b1) begin
        got_lock = 1'b1;
        break;
      end
    end
    total = total + 1;
    if (!got_lock) begin
      bad = bad + 1;
      $display("[TB] FAIL reset_lock: got locked=0 want 1");
    end
    repeat (5) @(negedge aclk);
    reset = 1'b1;
    @(negedge aclk);
    #2;
    total = total + 1;
    if ({s_axis_tready, locked, vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id, underflow, sof_err, dut.u_fifo.empty} !== 11'b1) begin
      bad = bad + 1;
      $display("[TB] FAIL midframe_reset: got %b want 00000000001", {s_axis_tready, locked, vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id, underflow, sof_err, dut.u_fifo.empty});
    end
    total = total + 1;
    if (vid_data !== '0) begin
      bad = bad + 1;
      $display("[TB] FAIL midframe_data: got %h want 0", vid_data);
    end
    beat_q.delete();
    exp_q.delete();
    @(negedge aclk);
    reset = 1'b0;
    repeat (20) @(negedge aclk);
  endtask

  task automatic test_nominal();
    bit ok;
    start_test();
    add_frame(16'h0001, -1, 32, -1, 0, -1);
    wait_drain(ok);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("[TB] FAIL nominal_drain: got %0d left want 0", exp_q.size());
    end
    total = total + 1;
    if (uf_cnt !== 0 || se_cnt !== 0) begin
      bad = bad + 1;
      $display("[TB] FAIL nominal_errors: got uf=%0d se=%0d want 0 0", uf_cnt, se_cnt);
    end
  endtask

  task automatic test_garbage();
    bit ok;
    beat_t b;
    start_test();
    for (int i = 0; i < 5; i++) begin
      b.data = 16'hDEA0 + DW'(i);
      b.user = 1'b0;
      b.last = 1'b0;
      b.gap  = 0;
      beat_q.push_back(b);
    end
    add_frame(16'h0001, -1, 32, -1, 0, -1);
    wait_drain(ok);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("[TB] FAIL garbage_drain: got %0d left want 0", exp_q.size());
    end
    total = total + 1;
    if (accepted_cnt !== 37) begin
      bad = bad + 1;
      $display("[TB] FAIL garbage_accepted: got %0d want 37", accepted_cnt);
    end
    total = total + 1;
    if (uf_cnt !== 0 || se_cnt !== 0) begin
      bad = bad + 1;
      $display("[TB] FAIL garbage_errors: got uf=%0d se=%0d want 0 0", uf_cnt, se_cnt);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    start_test();
    add_frame(16'h0001, -1, 32, -1, 0, -1);
    add_frame(16'h0101, -1, 12, 12, 200, -1);
    add_frame(16'h0201, -1, 32, -1, 0, -1);
    wait_drain(ok);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("[TB] FAIL underflow_drain: got %0d left want 0", exp_q.size());
    end
    total = total + 1;
    if (uf_cnt !== 1) begin
      bad = bad + 1;
      $display("[TB] FAIL underflow_count: got %0d want 1", uf_cnt);
    end
    total = total + 1;
    if (se_cnt !== 0) begin
      bad = bad + 1;
      $display("[TB] FAIL underflow_sof_err: got %0d want 0", se_cnt);
    end
  endtask

  task automatic test_misplaced_sof();
    bit ok;
    start_test();
    add_frame(16'h0001, 10, 10, -1, 0, -1);
    wait_drain(ok);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("[TB] FAIL missof_drain: got %0d left want 0", exp_q.size());
    end
    total = total + 1;
    if (se_cnt !== 1 || uf_cnt !== 0) begin
      bad = bad + 1;
      $display("[TB] FAIL missof_errors: got se=%0d uf=%0d want 1 0", se_cnt, uf_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    start_test();
    bp_check = 1'b1;
    add_frame(16'h1001, -1, 32, -1, 0, -1);
    add_frame(16'h2001, -1, 32, -1, 0, -1);
    wait_drain(ok);
    bp_check = 1'b0;
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("[TB] FAIL bp_drain: got %0d left want 0", exp_q.size());
    end
    total = total + 1;
    if (saw_full !== 1'b1) begin
      bad = bad + 1;
      $display("[TB] FAIL bp_full: got %b want 1", saw_full);
    end
    total = total + 1;
    if (accepted_cnt !== 64) begin
      bad = bad + 1;
      $display("[TB] FAIL bp_accepted: got %0d want 64", accepted_cnt);
    end
    total = total + 1;
    if (uf_cnt !== 0 || se_cnt !== 0) begin
      bad = bad + 1;
      $display("[TB] FAIL bp_errors: got uf=%0d se=%0d want 0 0", uf_cnt, se_cnt);
    end
  endtask

  task automatic test_eol();
    bit ok;
    start_test();
    add_frame(16'h0001, -1, EOL_EXP_PIX, -1, 0, 5);
    wait_drain(ok);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("[TB] FAIL eol_drain: got %0d left want 0", exp_q.size());
    end
    total = total + 1;
    if (se_cnt !== EOL_EXP_ERR || uf_cnt !== 0) begin
      bad = bad + 1;
      $display("[TB] FAIL eol_errors: got se=%0d uf=%0d want %0d 0", se_cnt, uf_cnt, EOL_EXP_ERR);
    end
  endtask

  initial begin
    reset        = 1'b1;
    total        = 0;
    bad          = 0;
    uf_cnt       = 0;
    se_cnt       = 0;
    accepted_cnt = 0;
    saw_full     = 1'b0;
    bp_check     = 1'b0;
    test_reset();
    test_nominal();
    test_garbage();
    test_underflow();
    test_misplaced_sof();
    test_backpressure();
    test_eol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
